// File: rtl/adder_serial_controller_if.sv
// Host-side handshake and operand/result bundle for adder_serial_controller.
// input_subtract exists only when ADDER_SERIAL_SUBTRACT_EN is defined.
interface adder_serial_controller_if #(
    parameter int WIDTH = 8
);
    logic             input_start;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
`ifdef ADDER_SERIAL_SUBTRACT_EN
    logic             input_subtract;
`endif
    logic             output_busy;
    logic             output_done;
    logic [WIDTH-1:0] output_sum;
    logic             output_carry;

    modport master (
`ifdef ADDER_SERIAL_SUBTRACT_EN
        output input_subtract,
`endif
        output input_start, input_a, input_b,
        input  output_busy, output_done, output_sum, output_carry
    );

    modport slave (
`ifdef ADDER_SERIAL_SUBTRACT_EN
        input  input_subtract,
`endif
        input  input_start, input_a, input_b,
        output output_busy, output_done, output_sum, output_carry
    );
endinterface

// File: rtl/adder_serial_controller.sv
// Bit-serial WIDTH-bit adder: one full-add cell (two half adders + OR) stepped LSB first.
// Define ADDER_SERIAL_SUBTRACT_EN to add input_subtract, computing A-B mod 2^WIDTH.
module adder_half_1bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module adder_serial_controller #(
    parameter int WIDTH = 8
) (
    input logic                       Clk,
    input logic                       Reset_n,
    adder_serial_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] result_shift;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             carry_out_q;
    logic [CNT_W-1:0] bit_count;
    logic             accept;
    logic             last_bit;
    logic             op_subtract;
    logic             sub_q;
    logic             b_bit;
    logic             c0;
    logic             s0;
    logic             c1;
    logic             sum_bit;
    logic             busy;
    logic             done;

    // Operands are only taken from IDLE or the DONE cycle; start during RUN is dropped.
    assign accept   = bus.input_start && (state == IDLE || state == DONE);
    assign last_bit = (bit_count == LAST_BIT);

`ifdef ADDER_SERIAL_SUBTRACT_EN
    assign op_subtract = bus.input_subtract;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= op_subtract;
        end
    end
`else
    assign op_subtract = 1'b0;
    assign sub_q       = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert B here, seed the carry with 1 on accept.
    assign b_bit = b_shift[0] ^ sub_q;

    adder_half_1bit ha0 (
        .a     (a_shift[0]),
        .b     (b_bit),
        .sum   (s0),
        .carry (c0)
    );

    adder_half_1bit ha1 (
        .a     (s0),
        .b     (carry),
        .sum   (sum_bit),
        .carry (c1)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.input_start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = bus.input_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            a_shift      <= '0;
            b_shift      <= '0;
            result_shift <= '0;
            sum_q        <= '0;
            carry        <= 1'b0;
            carry_out_q  <= 1'b0;
            bit_count    <= '0;
        end else if (accept) begin
            a_shift   <= bus.input_a;
            b_shift   <= bus.input_b;
            carry     <= op_subtract;
            bit_count <= '0;
        end else if (state == RUN) begin
            a_shift      <= a_shift >> 1;
            b_shift      <= b_shift >> 1;
            result_shift <= {sum_bit, result_shift[WIDTH-1:1]};
            carry        <= c0 | c1;
            bit_count    <= bit_count + 1'b1;
            if (last_bit) begin
                sum_q       <= {sum_bit, result_shift[WIDTH-1:1]};
                carry_out_q <= c0 | c1;
            end
        end
    end

    assign bus.output_busy  = busy;
    assign bus.output_done  = done;
    assign bus.output_sum   = sum_q;
    assign bus.output_carry = carry_out_q;
endmodule

// File: doc/adder_serial_controller.md
Name: adder_serial_controller

Overview:
- Bit-serial WIDTH-bit adder controller.
- Sequences one full-add cell, built from two adder_half_1bit instances plus an OR for the carry, over the operand bits LSB first, one bit per clock.
- Provides a start/busy/done handshake so a host can issue multi-bit additions on a minimal 1-bit datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous active-low reset.
- input_start  input  1  request; operands captured when accepted.
- input_a  input  WIDTH  operand A.
- input_b  input  WIDTH  operand B.
- output_busy  output  1  high while bits are being processed.
- output_done  output  1  one-cycle pulse, result valid.
- output_sum  output  WIDTH  result sum, held until next accepted start.
- output_carry  output  1  carry out of MSB, held with output_sum.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is synchronous and active-low, sampled only on the rising edge of Clk.
- Reset values: state IDLE, output_busy=0, output_done=0, output_sum=0, output_carry=0, internal carry=0, bit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: input_start=1 at edge E0 -> latch input_a/input_b into shift registers, clear carry, counter=0, go to RUN.
- RUN: each edge processes operand bit [counter].
  - ha0(a_i, b_i) -> c0, s0.
  - ha1(s0, carry) -> c1, sum_i.
  - carry <= c0 | c1.
  - sum_i is shifted into the result register from the MSB side; operand registers shift right.
  - counter increments.
  - At edge E(WIDTH), the last bit is processed: output_sum/output_carry are updated from the final result, and the FSM goes to DONE.
- DONE: output_done=1 for exactly one cycle, between E(WIDTH) and E(WIDTH+1). The next edge returns to IDLE, or to RUN if input_start=1 (back-to-back acceptance).
- output_busy: high from E0 to E(WIDTH); low in IDLE and DONE.
- Latency: WIDTH cycles from the accepting edge to the done pulse; sustained throughput is one operation per WIDTH+1 cycles.
- input_start while in RUN: ignored; no queueing, and operands are not re-sampled.
- input_a/input_b are sampled only on the accepting edge. Later changes to them have no effect on the operation in flight.
- output_sum/output_carry:
  - Change only at E(WIDTH) of an operation, or on reset.
  - Stable in IDLE and through the next RUN; they are not cleared on start.
- Arithmetic: unsigned, modulo 2^WIDTH; output_carry is bit WIDTH of the true sum.
- Reset mid-operation: the operation is abandoned and no done pulse is produced. All state and outputs take their reset values at that edge.
- Reset_n low together with input_start: reset wins.

Optional Feature:
- Macro: ADDER_SERIAL_SUBTRACT_EN.
- Defined:
  - Adds port input_subtract (input, 1), sampled with input_start.
  - When input_subtract=1, the B bits are inverted before ha0 and the initial carry is 1, so the operation computes A-B mod 2^WIDTH.
  - output_carry=1 means no borrow (A>=B).
- Undefined: the port does not exist; the block always adds, with initial carry 0.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, start pulse -> busy for 8 cycles; done pulse on the 8th edge after acceptance; sum=0x00, carry=0.
- a=0x5A, b=0x3C -> sum=0x96, carry=0. a=0xFF, b=0x01 -> sum=0x00, carry=1. a=0xFF, b=0xFF -> sum=0xFE, carry=1.
- Start held high continuously, with a=0x01, b=0x02 then a=0x10, b=0x20 presented at the DONE cycle:
  - First done gives sum=0x03.
  - start is ignored during RUN; the second operation is accepted at the DONE edge.
  - Second done gives sum=0x30.
  - No cycle has busy=1 and done=1 together.
- Start a=0x80, b=0x80; Reset_n low for 1 edge at RUN bit 4 -> busy=0, done never pulses, sum=0x00, carry=0. A fresh start then completes normally.
- Operands changed mid-RUN (a=0x12, b=0x34 latched, then inputs set to 0xFF) -> sum=0x46, carry=0.
- With ADDER_SERIAL_SUBTRACT_EN: 0x10-0x01 -> sum=0x0F, carry=1; 0x01-0x02 -> sum=0xFF, carry=0.
